// File: rtl/imem_load_ctrl_pkg.sv
// Shared constants for the instruction-memory load sequencer: FSM state
// encoding, default boot PC and the instruction-memory depth that the fetch
// stage is built with.
package imem_load_ctrl_pkg;

  // Instruction memory depth in 32-bit words; the fetch stage uses the same value.
  localparam int unsigned IMEM_DEPTH = 256;

  // Bytes packed into each instruction word.
  localparam int unsigned BYTES_PER_WORD = 4;

  // PC handed to the core when a load completes.
  localparam logic [31:0] BOOT_PC_DEFAULT = 32'h0000_0000;

  // Sequencer states (3-bit binary encoding).
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCollect = 3'd1;
  localparam logic [2:0] StSetaddr = 3'd2;
  localparam logic [2:0] StWrite   = 3'd3;
  localparam logic [2:0] StRelease = 3'd4;
  localparam logic [2:0] StRun     = 3'd5;

  // Byte address of a word index; upper bits of the index are dropped.
  function automatic logic [31:0] word_addr(input logic [31:0] idx);
    return {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs an accepted byte stream into 32-bit words. Owns the lane index,
// byte placement order and zero-fill of lanes left empty by a short final word.
// word_ready is a combinational strobe on the accept that completes a word;
// the completed word is visible on word/word_last from the next cycle until clr.
module imem_byte_packer
  import imem_load_ctrl_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        last,
  output logic        word_ready,
  output logic [31:0] word,
  output logic        word_last
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;
  logic        last_q, last_d;
  logic [1:0]  lane;

  localparam logic [1:0] LastLane = 2'(BYTES_PER_WORD - 1);

  // First byte goes to the top lane when MSB_FIRST, else to the bottom lane.
  assign lane = MSB_FIRST ? (LastLane - idx_q) : idx_q;

  // Word completes on the fourth byte or on the byte flagged last.
  assign word_ready = accept && ((idx_q == LastLane) || last);
  assign word       = buf_q;
  assign word_last  = last_q;

  // Next-state for lane index, packing buffer and last flag; clear wins.
  always_comb begin
    idx_d  = idx_q;
    buf_d  = buf_q;
    last_d = last_q;
    if (clr) begin
      idx_d  = '0;
      buf_d  = '0;
      last_d = 1'b0;
    end else if (accept) begin
      buf_d[{lane, 3'b000} +: 8] = data;
      idx_d  = idx_q + 2'd1;
      last_d = last;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      buf_q  <= '0;
      last_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      buf_q  <= buf_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot/load sequencer driving the fetch stage's newPC, WE and W_Ins inputs.
// Holds the core after reset, loads a byte image into instruction memory one
// word at a time (address cycle, then write cycle) and releases the core at
// BOOT_PC. Optional build macro: IMEM_LOAD_CHECKSUM_EN adds CHK_IN/CHK_SUM and
// rejects an image whose byte sum does not match CHK_IN.
module imem_load_ctrl
  import imem_load_ctrl_pkg::*;
#(
  parameter logic [31:0] BOOT_PC   = BOOT_PC_DEFAULT,
  parameter int unsigned MAX_WORDS = IMEM_DEPTH,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned CW       = $clog2(MAX_WORDS) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          LOAD_START,
  input  logic          IN_VALID,
  input  logic [7:0]    IN_DATA,
  input  logic          IN_LAST,
  output logic          IN_READY,
  input  logic [31:0]   CORE_NEWPC,
  output logic [31:0]   NEWPC,
  output logic          WE,
  output logic [31:0]   W_INS,
  output logic          HOLD,
  output logic [CW-1:0] WORD_CNT,
  output logic          ERR
`ifdef IMEM_LOAD_CHECKSUM_EN
  ,
  input  logic [7:0]    CHK_IN,
  output logic [7:0]    CHK_SUM
`endif
);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic          err_q, err_d;
  logic          in_ready_q;
  logic          we_q;
  logic [31:0]   w_ins_q;
  logic          hold_q;

  logic          accept;
  logic          pk_clr;
  logic          pk_word_ready;
  logic [31:0]   pk_word;
  logic          pk_word_last;
  logic          cnt_full;
  logic          chk_ok;
  logic [31:0]   cur_addr;

  assign accept   = IN_VALID && in_ready_q;
  assign cnt_full = (word_cnt_q == CW'(MAX_WORDS));
  assign cur_addr = word_addr(32'(word_cnt_q));

`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0] chk_q, chk_d;

  assign chk_ok  = (chk_q == CHK_IN);
  assign CHK_SUM = chk_q;

  // Running modulo-256 sum of accepted bytes; restarts with each load.
  always_comb begin
    chk_d = chk_q;
    if (LOAD_START && ((state_q == StIdle) || (state_q == StRun))) begin
      chk_d = '0;
    end else if (accept) begin
      chk_d = chk_q + IN_DATA;
    end
  end

  // Checksum register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chk_q <= '0;
    end else begin
      chk_q <= chk_d;
    end
  end
`else
  assign chk_ok = 1'b1;
`endif

  imem_byte_packer #(
    .MSB_FIRST (MSB_FIRST)
  ) u_packer (
    .clk        (CLK),
    .rst_n      (RST_N),
    .clr        (pk_clr),
    .accept     (accept),
    .data       (IN_DATA),
    .last       (IN_LAST),
    .word_ready (pk_word_ready),
    .word       (pk_word),
    .word_last  (pk_word_last)
  );

  // Sequencer next-state, word counter and error flag.
  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    err_d      = err_q;
    pk_clr     = 1'b0;
    case (state_q)
      StIdle, StRun: begin
        if (LOAD_START) begin
          state_d    = StCollect;
          word_cnt_d = '0;
          err_d      = 1'b0;
          pk_clr     = 1'b1;
        end
      end
      StCollect: begin
        if (pk_word_ready) begin
          state_d = StSetaddr;
        end
      end
      StSetaddr: begin
        if (cnt_full) begin
          // Memory full: drop this word, keep draining until the last byte.
          err_d   = 1'b1;
          pk_clr  = 1'b1;
          state_d = pk_word_last ? StIdle : StCollect;
        end else begin
          state_d = StWrite;
        end
      end
      StWrite: begin
        word_cnt_d = word_cnt_q + CW'(1);
        pk_clr     = 1'b1;
        if (!pk_word_last) begin
          state_d = StCollect;
        end else if (err_q || !chk_ok) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          state_d = StRelease;
        end
      end
      StRelease: begin
        state_d = StRun;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and registered outputs; outputs follow the state being entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= StIdle;
      word_cnt_q <= '0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      w_ins_q    <= '0;
      hold_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      err_q      <= err_d;
      in_ready_q <= (state_d == StCollect);
      we_q       <= (state_d == StWrite);
      hold_q     <= (state_d != StRun);
      if (state_d == StWrite) begin
        w_ins_q <= pk_word;
      end
    end
  end

  // NEWPC mux keyed on the registered state; RUN passes the core PC through.
  always_comb begin
    NEWPC = BOOT_PC;
    case (state_q)
      StCollect, StSetaddr, StWrite: NEWPC = cur_addr;
      StRun:                         NEWPC = CORE_NEWPC;
      default:                       NEWPC = BOOT_PC;
    endcase
  end

  assign IN_READY = in_ready_q;
  assign WE       = we_q;
  assign W_INS    = w_ins_q;
  assign HOLD     = hold_q;
  assign WORD_CNT = word_cnt_q;
  assign ERR      = err_q;

endmodule

// File: doc/imem_load_ctrl.md
Name: imem_load_ctrl

Overview:
Boot/load sequencer that owns the fetch stage's newPC, WE and W_Ins inputs. After reset it holds the core and accepts a byte stream over a valid/ready handshake, then packs bytes into 32-bit words. It writes each word into instruction memory by steering the fetch PC and pulsing WE. When the load completes it releases the core at BOOT_PC and forwards the core's next-PC unchanged.

Parameters:
BOOT_PC, 32'h0000_0000, PC driven on release; word-aligned.
MAX_WORDS, 256, instruction memory depth in words; equals IMEM size.
MSB_FIRST, 1, 1 = first byte of a word lands in [31:24]; 0 = first byte lands in [7:0].

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
LOAD_START  in  1  one-cycle pulse; starts a load from IDLE or RUN.
IN_VALID  in  1  byte-stream valid.
IN_DATA  in  8  byte payload.
IN_LAST  in  1  marks the final byte of the image; qualified by IN_VALID.
IN_READY  out  1  byte accepted when IN_VALID && IN_READY.
CORE_NEWPC  in  32  next-PC from the core; forwarded in RUN.
NEWPC  out  32  to fetch-stage newPC.
WE  out  1  to fetch-stage write enable; writes IMem[PC>>2] at the edge.
W_INS  out  32  to fetch-stage write data.
HOLD  out  1  stalls the core pipeline; high in every state except RUN.
WORD_CNT  out  $clog2(MAX_WORDS)+1  count of words written in the current load.
ERR  out  1  sticky overflow/error flag.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, NEWPC=BOOT_PC, WE=0, W_INS=0, HOLD=1, IN_READY=0, WORD_CNT=0, ERR=0.
  - Byte lane index and packing buffer clear.
- Fetch-stage timing (fixed): PC<=NEWPC at the edge; a write uses the PC already registered. A word therefore needs NEWPC=addr for one cycle, then WE=1 for the following cycle.
- IDLE: HOLD=1, IN_READY=0, NEWPC=BOOT_PC.
  - LOAD_START -> COLLECT; clears WORD_CNT, ERR, lane index and buffer.
- COLLECT: IN_READY=1.
  - Each accepted byte goes into lane idx (MSB_FIRST order), then idx++.
  - idx reaching 4, or acceptance of IN_LAST -> SETADDR. Unfilled lanes are zero.
- SETADDR (1 cycle): IN_READY=0, NEWPC=WORD_CNT*4 (32-bit, upper bits zero) -> WRITE.
- WRITE (1 cycle): WE=1, W_INS=packed word, NEWPC held at WORD_CNT*4.
  - WORD_CNT++ at the end of the cycle; buffer and idx clear.
  - If the word held IN_LAST -> RELEASE; otherwise -> COLLECT.
- Throughput: 4-byte word = 4 accept cycles + 2 write cycles. IN_READY is deasserted during SETADDR and WRITE.
- Overflow:
  - In SETADDR, if WORD_CNT==MAX_WORDS, set ERR=1 and skip WRITE; no WE is issued and WORD_CNT saturates.
  - Remaining bytes are accepted and dropped until IN_LAST, then go to RELEASE only if ERR=0, else IDLE.
  - The IN_LAST word that overflows sets ERR and goes to IDLE.
- RELEASE (1 cycle): NEWPC=BOOT_PC, HOLD=1 -> RUN. The core's first fetch after release is at BOOT_PC.
- RUN: HOLD=0, WE=0, NEWPC=CORE_NEWPC (combinational pass-through), IN_READY=0.
  - LOAD_START -> COLLECT; HOLD rises in the same cycle as the transition, registered.
- LOAD_START in COLLECT/SETADDR/WRITE/RELEASE is ignored.
- IN_LAST together with IN_VALID=0 is ignored.
- Empty image is not possible: IN_LAST always carries a byte.
- Reset mid-load aborts immediately. IMEM contents already written are left as they are.
- All outputs except the NEWPC mux are registered. NEWPC is a mux selected by the registered state.

Optional Feature:
IMEM_LOAD_CHECKSUM_EN:
- With the macro defined:
  - Extra input CHK_IN[7:0] and output CHK_SUM[7:0].
  - CHK_SUM is the modulo-256 sum of all accepted bytes; it clears on LOAD_START.
  - On completion, if CHK_SUM != CHK_IN, set ERR=1 and go to IDLE instead of RELEASE.
- Without the macro: the ports and logic are absent; completion always goes to RELEASE when ERR=0.

Decomposition:
- Shared package/header holds:
  - state encoding constants: IDLE, COLLECT, SETADDR, WRITE, RELEASE, RUN (3-bit);
  - BOOT_PC default;
  - IMEM depth constant, shared with the fetch stage.
- One natural sub-module: imem_byte_packer. It owns the lane index, MSB_FIRST placement and zero-fill, and emits word_ready/word/last.
- The FSM, address counter and NEWPC mux stay in the top level.

Test Plan:
- Reset, then LOAD_START, then 8 bytes 11 22 33 44 55 66 77 88 (LAST on 88), MSB_FIRST=1 -> WE pulses with NEWPC 0x0 then 0x4, W_INS 0x11223344 then 0x55667788; WORD_CNT=2; RELEASE NEWPC=0; RUN HOLD=0.
- 5-byte image AA BB CC DD EE (LAST on EE) -> second word 0xEE000000 at address 0x4; with MSB_FIRST=0 the first word is 0xDDCCBBAA.
- IN_VALID toggling 1-0-1 with stalls -> no duplicate or lost bytes; IN_READY=0 during SETADDR/WRITE and no byte accepted then.
- MAX_WORDS=2, 3-word image -> exactly 2 WE pulses, ERR=1, final state IDLE, HOLD stays 1.
- RUN with CORE_NEWPC=0x40 -> NEWPC=0x40 the same cycle. Then LOAD_START -> HOLD=1 on the next cycle; RST_N low mid-COLLECT -> all outputs at reset values immediately.
- With IMEM_LOAD_CHECKSUM_EN, bytes 01 02 03 04 and CHK_IN=0x0A -> RUN; CHK_IN=0x0B -> ERR=1 and IDLE.
